// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   WORD_W           : datapath word width
//   RESET_PC_DEFAULT : default byte address fetched first after reset
//   fetch_entry_t    : one fetched word tagged with its byte PC
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t between the memory response and decode.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   flush        : empties the FIFO; wins over push and pop in the same cycle
//   push, i_data : write one entry at the tail
//   pop          : remove the head entry (ignored when empty)
//   count        : current occupancy, 0..DEPTH
//   head         : entry at the head; meaningful only when count != 0
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               i_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;

    assign w_do_pop = pop && (r_count != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)     r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(push) - CW'(w_do_pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy alone decides which
    // entries are live, so clearing the data would only cost logic.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) r_mem[r_wr_ptr] <= i_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Front-end fetch unit: owns the PC, drives one word address per cycle into
// the synchronous instruction memory, tags each one-cycle-latency response
// with its PC and buffers it in fetch_fifo for decode.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   imem_addr         : word index {2'b00, pc[31:2]}
//   imem_instruction  : memory data for the previous cycle's imem_addr
//   redirect_valid/pc : taken branch/jump; flushes and restarts at target
//   if_valid/ready    : handshake to decode
//   if_instr, if_pc   : head word and its byte PC, zero when if_valid = 0
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   r_pc;
    logic          r_inflight_valid;
    logic [31:0]   r_inflight_pc;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit_used;
    logic          w_issue;
    logic          w_flush;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // Credit check uses registered state only, so if_ready never reaches
    // imem_addr combinationally. Counting the inflight word guarantees the
    // response always has a free slot when it lands.
    assign w_credit_used = {1'b0, w_count} + (CW+1)'(r_inflight_valid);
    assign w_issue       = !reset && !redirect_valid
                           && (w_credit_used < (CW+1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc             <= RESET_PC & ~32'h3;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= '0;
        end else if (redirect_valid) begin
            // Dropping the inflight flag discards the response due next cycle.
            r_pc             <= redirect_pc & ~32'h3;
            r_inflight_valid <= 1'b0;
        end else begin
            r_inflight_valid <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 32'd4;
            end
        end
    end

    assign imem_addr = {2'b00, r_pc[31:2]};

    assign w_flush     = reset || redirect_valid;
    assign w_pop       = if_valid && if_ready;
    assign w_push_data = '{pc: r_inflight_pc, instr: imem_instruction};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .flush  (w_flush),
        .push   (r_inflight_valid),
        .i_data (w_push_data),
        .pop    (w_pop),
        .count  (w_count),
        .head   (w_head)
    );

    assign if_valid = (w_count != '0);
    assign if_instr = if_valid ? w_head.instr : '0;
    assign if_pc    = if_valid ? w_head.pc    : '0;

endmodule
